// File: rtl/score_bcd_counter.sv
// Saturating two-digit BCD score fed by edge-detected point strobes; awards are queued and applied one count per clock.
// Optional HIGH_SCORE_EN adds a high-score register (hi_ones/hi_tens) updated on clear and when score_max rises.
module score_bcd_counter #(
  parameter int MAX_SCORE = 99,
  parameter int PEND_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       point_in,
  input  logic [3:0] add_val,
  input  logic       clear,
  output logic [3:0] bcd_ones,
  output logic [3:0] bcd_tens,
  output logic       busy,
  output logic       score_max
`ifdef HIGH_SCORE_EN
  ,
  output logic [3:0] hi_ones,
  output logic [3:0] hi_tens
`endif
);

  localparam logic [3:0] MAX_TENS = 4'(MAX_SCORE / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_SCORE % 10);
  localparam int         SUM_W    = ((PEND_W > 4) ? PEND_W : 4) + 1;
  localparam logic [SUM_W-1:0] PEND_SAT = SUM_W'((2 ** PEND_W) - 1);

  typedef enum logic {ST_IDLE, ST_COUNT} state_t;

  state_t            r_state;
  logic              r_point_q;
  logic [PEND_W-1:0] r_pend;
  logic [3:0]        r_ones;
  logic [3:0]        r_tens;
  logic              r_score_max;

  logic              w_event;
  logic              w_at_max;
  logic              w_dec;
  logic [3:0]        w_ones_next;
  logic [3:0]        w_tens_next;
  logic              w_next_max;
  logic [SUM_W-1:0]  w_pend_sum;
  logic [PEND_W-1:0] w_pend_sat;
  logic [PEND_W-1:0] w_pend_next;

  assign w_event  = point_in & ~r_point_q;
  assign w_at_max = (r_tens == MAX_TENS) && (r_ones == MAX_ONES);
  assign w_dec    = (r_pend != '0) && !w_at_max;

  always_comb begin
    w_ones_next = r_ones;
    w_tens_next = r_tens;
    if (w_dec) begin
      if (r_ones == 4'd9) begin
        w_ones_next = 4'd0;
        w_tens_next = r_tens + 4'd1;
      end else begin
        w_ones_next = r_ones + 4'd1;
      end
    end
  end

  assign w_next_max = (w_tens_next == MAX_TENS) && (w_ones_next == MAX_ONES);

  // Decrement and award land in the same cycle; the sum clamps instead of wrapping.
  assign w_pend_sum  = SUM_W'(r_pend) - SUM_W'(w_dec)
                     + (w_event ? SUM_W'(add_val) : SUM_W'(0));
  assign w_pend_sat  = (w_pend_sum > PEND_SAT) ? {PEND_W{1'b1}} : w_pend_sum[PEND_W-1:0];
  assign w_pend_next = (w_at_max || w_next_max) ? '0 : w_pend_sat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_point_q   <= 1'b0;
      r_pend      <= '0;
      r_ones      <= 4'd0;
      r_tens      <= 4'd0;
      r_score_max <= 1'b0;
    end else begin
      r_point_q <= point_in;
      if (clear) begin
        r_state     <= ST_IDLE;
        r_pend      <= '0;
        r_ones      <= 4'd0;
        r_tens      <= 4'd0;
        r_score_max <= 1'b0;
      end else begin
        r_pend      <= w_pend_next;
        r_ones      <= w_ones_next;
        r_tens      <= w_tens_next;
        r_score_max <= w_next_max;
        case (r_state)
          ST_IDLE:  if (w_pend_next != '0) r_state <= ST_COUNT;
          ST_COUNT: if (w_pend_next == '0) r_state <= ST_IDLE;
          default:  r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bcd_ones  = r_ones;
  assign bcd_tens  = r_tens;
  assign busy      = (r_state == ST_COUNT);
  assign score_max = r_score_max;

`ifdef HIGH_SCORE_EN
  logic [3:0] r_hi_ones;
  logic [3:0] r_hi_tens;
  logic       w_cur_gt;
  logic       w_max_rise;

  // Tens decide first; ones only break a tie.
  assign w_cur_gt   = (r_tens > r_hi_tens) || ((r_tens == r_hi_tens) && (r_ones > r_hi_ones));
  assign w_max_rise = !clear && w_next_max && !r_score_max;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi_ones <= 4'd0;
      r_hi_tens <= 4'd0;
    end else if (clear && w_cur_gt) begin
      r_hi_ones <= r_ones;
      r_hi_tens <= r_tens;
    end else if (w_max_rise) begin
      r_hi_ones <= w_ones_next;
      r_hi_tens <= w_tens_next;
    end
  end

  assign hi_ones = r_hi_ones;
  assign hi_tens = r_hi_tens;
`endif

endmodule

// File: doc/score_bcd_counter.md
Name: score_bcd_counter

Overview:
Upstream feeder of the score display stage. Converts game "point" events into a saturating two-digit BCD score (bcd_ones, bcd_tens) that the display multiplexer consumes directly. Point values of 1-15 are queued and applied serially, one count per clock, so the BCD outputs always hold a legal value. Sits between game logic (point/clear strobes) and the display multiplexer.

Parameters:
MAX_SCORE, 99, saturation ceiling as a decimal value; legal range 1..99.
PEND_W, 4, width of the pending-points accumulator; pending saturates at 2^PEND_W-1.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
point_in  input  1  point strobe from game logic, synchronous to clk; level, edge-detected internally
add_val  input  4  points to award on a point_in rising edge; 0 means award nothing
clear  input  1  synchronous score clear, level-sensitive, highest priority
bcd_ones  output  4  ones digit, 0-9
bcd_tens  output  4  tens digit, 0-9
busy  output  1  high while pending points remain to be applied
score_max  output  1  high while score == MAX_SCORE

Behaviour:
- Reset (reset=0, async): bcd_ones=0, bcd_tens=0, pending=0, point_q=0, busy=0, score_max=0.
- Edge detect: point_q registers point_in. Event = point_in & ~point_q. A held-high point_in awards once only.
- Pending accumulator, PEND_W bits. Each cycle: next = pending - dec + (event ? add_val : 0). dec=1 when pending!=0 and score<MAX_SCORE. Result saturates at 2^PEND_W-1 and never wraps.
- FSM states:
  - IDLE: pending==0; busy=0.
  - COUNT: pending!=0 and score<MAX_SCORE; busy=1.
  - IDLE->COUNT on an event with add_val!=0. COUNT->IDLE when pending reaches 0 or the score reaches MAX_SCORE.
  - busy is registered and equals (next pending != 0) computed in the same cycle.
- Increment in COUNT: each cycle the score rises by exactly 1 in BCD.
  - ones==9: ones<=0, tens<=tens+1.
  - Otherwise ones<=ones+1.
  - Latency: the first increment is visible on the clock edge after the event is registered. An event in cycle N gives the first change at edge N+1, and an award of k completes at edge N+k.
- Saturation: when the score equals MAX_SCORE, remaining pending is discarded (pending<=0) and new events are ignored. score_max=1 from the same edge the score reaches MAX_SCORE.
- Simultaneous event during COUNT: add_val is added to pending in the same cycle as the decrement; no event is lost unless the accumulator saturates.
- clear=1: next edge sets score=00, pending=0, busy=0, score_max=0. An event in the same cycle is dropped. point_q still updates, so a point held across a clear release does not re-trigger.
- Reset mid-COUNT: all state returns to reset values immediately; no partial update.
- Outputs are always legal BCD (each digit 0-9); the tens digit never exceeds MAX_SCORE/10.

Optional Feature:
HIGH_SCORE_EN
- Defined: adds output ports hi_ones[3:0] and hi_tens[3:0] (reset 0). On each clear, and whenever score_max rises, the high-score register loads the current score if it is greater (two-digit BCD compare, tens first). clear itself does not reset the high score; only reset does.
- Undefined: ports and register are absent, and behaviour is otherwise identical.

Test Plan:
- Reset then idle 10 cycles -> bcd_tens=0, bcd_ones=0, busy=0, score_max=0 throughout.
- add_val=3, one point_in pulse -> busy=1 for 3 cycles; score steps 01,02,03; busy=0 after; point_in held high 20 cycles adds only 3.
- Score 08, add_val=5 -> 09,10,11,12,13; verifies ones 9->0 with tens carry.
- Score 97, add_val=9 -> 98,99 then stop; score_max=1, pending discarded, busy=0; a further pulse leaves 99.
- During COUNT from 00 with add_val=4, second event add_val=6 two cycles later -> final score 10, no lost counts; clear asserted mid-COUNT -> 00 next edge, busy=0.
- HIGH_SCORE_EN: reach 42, clear, reach 17, clear -> hi_tens=4, hi_ones=2; reset -> hi=00.
